axi4_lite_master_engine: RTL and testbench

Synthesizable, parametrised AXI4-Lite master. It converts a simple command/response stream into AXI4-Lite channel activity, and drives the same five-channel pin set the master interface carries. It supports up to MAX_OUTSTANDING transactions in flight, returns responses on a single stream, and sits between test/CPU-side logic and the AXI4-Lite fabric.

---
 rtl/axi4_lite_globals_pkg.sv | 22 ++
 rtl/axi4_lite_outstanding_counter.sv | 21 ++
 rtl/axi4_lite_master_engine.sv | 148 ++++++++++++++
 tb/tb_axi4_lite_master_engine.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_globals_pkg.sv
// Shared AXI4-Lite defaults: bus widths, response codes and the command word.
package axi4_lite_globals_pkg;

  localparam int AXIL_ADDRESS_WIDTH = 32;
  localparam int AXIL_DATA_WIDTH    = 32;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_e;

  typedef struct packed {
    logic                            write;
    logic [AXIL_ADDRESS_WIDTH-1:0]   addr;
    logic [2:0]                      prot;
    logic [AXIL_DATA_WIDTH-1:0]      wdata;
    logic [AXIL_DATA_WIDTH/8-1:0]    wstrb;
  } axi_cmd_t;

endpackage

// File: rtl/axi4_lite_outstanding_counter.sv
// In-flight transaction counter: +1 on accept, -1 on response consume, floor at 0.
module axi4_lite_outstanding_counter #(
  parameter int MAX_OUTSTANDING = 4
)(
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       inc,
  input  logic       dec,
  output logic [3:0] count,
  output logic       full
);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)                          count <= '0;
    else if (inc && !dec)                  count <= count + 4'd1;
    else if (!inc && dec && count != '0)   count <= count - 4'd1;
  end

  assign full = (count == 4'(MAX_OUTSTANDING));

endmodule

// File: rtl/axi4_lite_master_engine.sv
// Command/response stream to AXI4-Lite master bridge with a single issue slot.
// Optional response watchdog built when AXI4_LITE_MASTER_TIMEOUT_EN is defined.
module axi4_lite_master_engine
  import axi4_lite_globals_pkg::*;
#(
  parameter int ADDRESS_WIDTH   = AXIL_ADDRESS_WIDTH,
  parameter int DATA_WIDTH      = AXIL_DATA_WIDTH,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 256
)(
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
  input  logic [2:0]               cmd_prot,
  input  logic [DATA_WIDTH-1:0]    cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]  cmd_wstrb,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_write,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic [1:0]               rsp_resp,
  output logic [ADDRESS_WIDTH-1:0] awaddr,
  output logic [2:0]               awprot,
  output logic                     awvalid,
  input  logic                     awready,
  output logic [DATA_WIDTH-1:0]    wdata,
  output logic [DATA_WIDTH/8-1:0]  wstrb,
  output logic                     wvalid,
  input  logic                     wready,
  input  logic [1:0]               bresp,
  input  logic                     bvalid,
  output logic                     bready,
  output logic [ADDRESS_WIDTH-1:0] araddr,
  output logic [2:0]               arprot,
  output logic                     arvalid,
  input  logic                     arready,
  input  logic [DATA_WIDTH-1:0]    rdata,
  input  logic [1:0]               rresp,
  input  logic                     rvalid,
  output logic                     rready,
  output logic [3:0]               outstanding,
  output logic                     timeout_err
);

  localparam int SW = DATA_WIDTH/8;

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [2:0]               prot;
    logic [DATA_WIDTH-1:0]    wdata;
    logic [SW-1:0]            wstrb;
  } iss_t;

  iss_t iss_q;
  logic full, acc, b_hs, r_hs, rsp_hs;

  // Issue slot is busy exactly while any of its channel valids is still up.
  assign cmd_ready = aresetn & ~(awvalid | wvalid | arvalid) & ~full;
  assign acc       = cmd_valid & cmd_ready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      iss_q   <= '0;
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      arvalid <= 1'b0;
    end else if (acc) begin
      iss_q   <= '{addr: cmd_addr, prot: cmd_prot, wdata: cmd_wdata, wstrb: cmd_wstrb};
      awvalid <= cmd_write;
      wvalid  <= cmd_write;
      arvalid <= ~cmd_write;
    end else begin
      awvalid <= awvalid & ~awready;
      wvalid  <= wvalid  & ~wready;
      arvalid <= arvalid & ~arready;
    end
  end

  assign awaddr = iss_q.addr;
  assign awprot = iss_q.prot;
  assign wdata  = iss_q.wdata;
  assign wstrb  = iss_q.wstrb;
  assign araddr = iss_q.addr;
  assign arprot = iss_q.prot;

  // B wins a same-cycle collision; R waits until the holding register frees again.
  assign bready = aresetn & ~rsp_valid;
  assign rready = aresetn & ~rsp_valid & ~bvalid;
  assign b_hs   = bvalid & bready;
  assign r_hs   = rvalid & rready;
  assign rsp_hs = rsp_valid & rsp_ready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= OKAY;
    end else if (b_hs) begin
      rsp_valid <= 1'b1;
      rsp_write <= 1'b1;
      rsp_rdata <= '0;
      rsp_resp  <= bresp;
    end else if (r_hs) begin
      rsp_valid <= 1'b1;
      rsp_write <= 1'b0;
      rsp_rdata <= rdata;
      rsp_resp  <= rresp;
    end else if (rsp_hs) begin
      rsp_valid <= 1'b0;
    end
  end

  axi4_lite_outstanding_counter #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_cnt (
    .aclk    (aclk),
    .aresetn (aresetn),
    .inc     (acc),
    .dec     (rsp_hs),
    .count   (outstanding),
    .full    (full)
  );

`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tcnt        <= '0;
      timeout_err <= 1'b0;
    end else if (outstanding == '0 || b_hs || r_hs) begin
      tcnt <= '0;
    end else if (tcnt != TW'(TIMEOUT_CYCLES)) begin
      tcnt <= tcnt + 1'b1;
      if (tcnt == TW'(TIMEOUT_CYCLES - 1)) timeout_err <= 1'b1;
    end
  end
`else
  // Constant 0; the comparison only keeps the parameter referenced in this build.
  assign timeout_err = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_axi4_lite_master_engine.sv
// Randomized bench with a queue-based scoreboard of channel traffic and responses.
module tb_axi4_lite_master_engine;
  import axi4_lite_globals_pkg::*;

  localparam int AW = 32, DW = 32, SW = 4, MAXO = 4, TO = 16;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [2:0] cmd_prot;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_wstrb;
  logic rsp_valid, rsp_ready, rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic [1:0] rsp_resp;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0] awprot, arprot;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [SW-1:0] wstrb;
  logic [1:0] bresp, rresp;
  logic [3:0] outstanding;
  logic timeout_err;

  axi4_lite_master_engine #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO), .TIMEOUT_CYCLES(TO)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_prot(cmd_prot), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .outstanding(outstanding), .timeout_err(timeout_err)
  );

  typedef struct {
    logic          w;
    logic [DW-1:0] d;
    logic [1:0]    r;
  } rsp_t;

  // Reference model: what is owed on each channel, and what the response stream owes.
  axi_cmd_t exp_aw[$], exp_w[$], exp_ar[$];
  rsp_t     rsp_q[$];
  int m_out, m_tcnt;
  bit m_terr;

  int checks = 0, fails = 0;
  bit chk_en = 0, auto_slv = 0, spur = 0, b_done = 0, r_done = 0;
  int s_aw_n = 0, s_w_n = 0, s_ar_n = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge aclk) begin : cmp
    bit idle;
    if (chk_en) begin
      idle = (exp_aw.size() == 0) && (exp_w.size() == 0) && (exp_ar.size() == 0);
      chk("cmd_ready", cmd_ready, idle && (m_out < MAXO));
      chk("awvalid", awvalid, exp_aw.size() > 0);
      if (exp_aw.size() > 0) begin
        chk("awaddr", awaddr, exp_aw[0].addr);
        chk("awprot", awprot, exp_aw[0].prot);
      end
      chk("wvalid", wvalid, exp_w.size() > 0);
      if (exp_w.size() > 0) begin
        chk("wdata", wdata, exp_w[0].wdata);
        chk("wstrb", wstrb, exp_w[0].wstrb);
      end
      chk("arvalid", arvalid, exp_ar.size() > 0);
      if (exp_ar.size() > 0) begin
        chk("araddr", araddr, exp_ar[0].addr);
        chk("arprot", arprot, exp_ar[0].prot);
      end
      chk("rsp_valid", rsp_valid, rsp_q.size() > 0);
      if (rsp_q.size() > 0) begin
        chk("rsp_write", rsp_write, rsp_q[0].w);
        chk("rsp_rdata", rsp_rdata, rsp_q[0].d);
        chk("rsp_resp", rsp_resp, rsp_q[0].r);
      end
      chk("bready", bready, rsp_q.size() == 0);
      chk("rready", rready, (rsp_q.size() == 0) && !bvalid);
      chk("outstanding", outstanding, m_out);
      chk("timeout_err", timeout_err, m_terr);
    end
  end

  task automatic slave_drive();
    awready = 1'($urandom_range(0, 1));
    wready  = 1'($urandom_range(0, 1));
    arready = 1'($urandom_range(0, 1));
    if (b_done) begin bvalid = 1'b0; b_done = 0; end
    if (r_done) begin rvalid = 1'b0; r_done = 0; end
    if (!bvalid && ((s_aw_n > 0 && s_w_n > 0) || spur) && $urandom_range(0, 2) == 0) begin
      bvalid = 1'b1; bresp = 2'($urandom);
    end
    if (!rvalid && (s_ar_n > 0 || spur) && $urandom_range(0, 2) == 0) begin
      rvalid = 1'b1; rresp = 2'($urandom); rdata = $urandom;
    end
  endtask

  // Called just after a falling edge with inputs set; returns just after the next one.
  task automatic step();
    bit acc, awh, wh, arh, bh, rh, ch;
    int o;
    axi_cmd_t c;
    rsp_t r;
    if (auto_slv) slave_drive();
    #1;
    acc = cmd_valid && cmd_ready;
    awh = awvalid && awready;  wh = wvalid && wready;  arh = arvalid && arready;
    bh  = bvalid && bready;    rh = rvalid && rready;  ch = rsp_valid && rsp_ready;
    o = m_out;
    if (awh && exp_aw.size() > 0) begin void'(exp_aw.pop_front()); s_aw_n++; end
    if (wh  && exp_w.size()  > 0) begin void'(exp_w.pop_front());  s_w_n++;  end
    if (arh && exp_ar.size() > 0) begin void'(exp_ar.pop_front()); s_ar_n++; end
    if (acc) begin
      c.write = cmd_write; c.addr = cmd_addr; c.prot = cmd_prot;
      c.wdata = cmd_wdata; c.wstrb = cmd_wstrb;
      if (cmd_write) begin exp_aw.push_back(c); exp_w.push_back(c); end
      else exp_ar.push_back(c);
    end
    if (ch && rsp_q.size() > 0) void'(rsp_q.pop_front());
    if (bh) begin
      r.w = 1'b1; r.d = '0; r.r = bresp; rsp_q.push_back(r); b_done = 1;
      if (s_aw_n > 0 && s_w_n > 0) begin s_aw_n--; s_w_n--; end
    end
    if (rh) begin
      r.w = 1'b0; r.d = rdata; r.r = rresp; rsp_q.push_back(r); r_done = 1;
      if (s_ar_n > 0) s_ar_n--;
    end
    if (acc && !ch) m_out++;
    else if (!acc && ch && m_out > 0) m_out--;
`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
    if (o == 0 || bh || rh) m_tcnt = 0;
    else if (m_tcnt < TO) begin
      m_tcnt++;
      if (m_tcnt == TO) m_terr = 1;
    end
`else
    if (o < 0) m_tcnt = 0;
`endif
    @(negedge aclk);
    #1;
  endtask

  task automatic do_reset();
    aresetn = 1'b0; chk_en = 0;
    exp_aw.delete(); exp_w.delete(); exp_ar.delete(); rsp_q.delete();
    m_out = 0; m_tcnt = 0; m_terr = 0;
    s_aw_n = 0; s_w_n = 0; s_ar_n = 0; b_done = 0; r_done = 0;
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_prot = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 0; awready = 0; wready = 0; arready = 0;
    bvalid = 0; bresp = '0; rvalid = 0; rresp = '0; rdata = '0;
    #2;
    chk("rst_awvalid", awvalid, 0);   chk("rst_wvalid", wvalid, 0);
    chk("rst_arvalid", arvalid, 0);   chk("rst_outstanding", outstanding, 0);
    chk("rst_cmd_ready", cmd_ready, 0); chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_bready", bready, 0);     chk("rst_rready", rready, 0);
    chk("rst_awaddr", awaddr, 0);     chk("rst_timeout", timeout_err, 0);
    @(negedge aclk); #1;
    aresetn = 1'b1; chk_en = 1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bit done;
    do_reset();

    // Write with awready two cycles ahead of wready.
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h10; cmd_wdata = 32'hDEADBEEF; cmd_wstrb = 4'hF; cmd_prot = 3'd0;
    step(); cmd_valid = 0;
    chk("t1_awvalid", awvalid, 1); chk("t1_awaddr", awaddr, 32'h10); chk("t1_wdata", wdata, 32'hDEADBEEF);
    awready = 1; step(); awready = 0; step(); step();
    chk("t1_aw_dropped", awvalid, 0); chk("t1_w_held", wvalid, 1);
    wready = 1; step(); wready = 0;
    chk("t1_issue_free", cmd_ready, 1);
    bvalid = 1; bresp = 2'b00; step(); bvalid = 0;
    chk("t1_rsp_valid", rsp_valid, 1); chk("t1_rsp_write", rsp_write, 1);
    chk("t1_rsp_resp", rsp_resp, 2'b00); chk("t1_out1", outstanding, 1);
    rsp_ready = 1; step(); rsp_ready = 0;
    chk("t1_out0", outstanding, 0);

    // Read returning SLVERR.
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h20; step(); cmd_valid = 0;
    chk("t2_araddr", araddr, 32'h20);
    arready = 1; step(); arready = 0;
    rvalid = 1; rdata = 32'h12345678; rresp = 2'b10; step(); rvalid = 0;
    chk("t2_rdata", rsp_rdata, 32'h12345678); chk("t2_resp", rsp_resp, 2'b10); chk("t2_write", rsp_write, 0);
    rsp_ready = 1; step(); rsp_ready = 0;

    // Fill to MAX_OUTSTANDING, then free one slot.
    arready = 1;
    for (int i = 0; i < MAXO; i++) begin
      cmd_valid = 1; cmd_write = 0; cmd_addr = 32'(i * 4); step(); cmd_valid = 0; step();
    end
    arready = 0;
    chk("t3_full_ready", cmd_ready, 0); chk("t3_full_out", outstanding, 4);
    rvalid = 1; rdata = 32'hA5A50001; rresp = 2'b00; step(); rvalid = 0;
    chk("t3_held_ready", cmd_ready, 0);
    rsp_ready = 1; step(); rsp_ready = 0;
    chk("t3_freed_ready", cmd_ready, 1); chk("t3_freed_out", outstanding, 3);
    for (int i = 0; i < 3; i++) begin
      rvalid = 1; rdata = $urandom; step(); rvalid = 0; rsp_ready = 1; step(); rsp_ready = 0;
    end
    chk("t3_drained", outstanding, 0);

    // B and R colliding in one cycle.
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h40; step(); cmd_valid = 0;
    awready = 1; wready = 1; step(); awready = 0; wready = 0;
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h44; step(); cmd_valid = 0;
    arready = 1; step(); arready = 0;
    chk("t4_out2", outstanding, 2);
    bvalid = 1; bresp = 2'b01; rvalid = 1; rdata = 32'hCAFEF00D; rresp = 2'b00; rsp_ready = 1;
    step(); bvalid = 0;
    chk("t4_b_first", rsp_write, 1); chk("t4_b_resp", rsp_resp, 2'b01);
    step();
    chk("t4_gap", rsp_valid, 0);
    step(); rvalid = 0;
    chk("t4_r_valid", rsp_valid, 1); chk("t4_r_write", rsp_write, 0); chk("t4_r_data", rsp_rdata, 32'hCAFEF00D);
    step(); rsp_ready = 0;
    chk("t4_out0", outstanding, 0);

    // Reset with a write address pending and two transactions in flight.
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h50; step(); cmd_valid = 0;
    arready = 1; step(); arready = 0;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h54; step(); cmd_valid = 0;
    chk("t5_awvalid", awvalid, 1); chk("t5_out2", outstanding, 2);
    do_reset();
    repeat (5) step();
    chk("t5_no_rsp", rsp_valid, 0);

`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h60; step(); cmd_valid = 0;
    repeat (TO - 1) step();
    chk("t6_before", timeout_err, 0);
    step();
    chk("t6_set", timeout_err, 1);
    repeat (5) step();
    chk("t6_sticky", timeout_err, 1);
    do_reset();
`endif

    // Randomized traffic against the auto slave.
    auto_slv = 1;
    for (int i = 0; i < 3000; i++) begin
      cmd_valid = 1'($urandom_range(0, 1)); cmd_write = 1'($urandom_range(0, 1));
      cmd_addr = $urandom; cmd_prot = 3'($urandom); cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
      rsp_ready = 1'($urandom_range(0, 1));
      step();
    end
    // Unsolicited responses, including with nothing in flight.
    cmd_valid = 0; spur = 1;
    for (int i = 0; i < 200; i++) begin
      rsp_ready = 1'($urandom_range(0, 1)); step();
    end
    spur = 0;
    done = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      rsp_ready = 1; step();
      done = (exp_aw.size() == 0) && (exp_w.size() == 0) && (exp_ar.size() == 0) && (rsp_q.size() == 0)
             && (s_aw_n == 0) && (s_w_n == 0) && (s_ar_n == 0) && !bvalid && !rvalid;
    end
    chk("drain_done", done, 1);
    chk("drain_out0", outstanding, 0);

    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
